// File: rtl/ws_array_ctrl.sv
// Tile sequencer for a weight-stationary systolic array: weight preload, ifmap
// streaming and per-column bottom-row psum-valid tracking.
module ws_array_ctrl #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int VW      = 16,
  parameter int ARR_LAT = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [VW-1:0]                        num_vec,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 wght_rd_en,
  output logic [(ROWS>1?$clog2(ROWS):1)-1:0]   wght_rd_addr,
  output logic                                 load_wght,
  output logic                                 ifmap_rd_en,
  output logic [VW-1:0]                        ifmap_rd_addr,
  output logic [COLS-1:0]                      psum_valid,
  output logic [VW-1:0]                        psum_idx
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int VLEN = ARR_LAT + COLS - 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [VW-1:0]  cnt, cnt_nxt, nvec;
  logic [VLEN-1:0] vpipe;
  logic [VW-1:0]  ipipe [ARR_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      nvec  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) nvec <= num_vec;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_W;
          cnt_nxt   = '0;
        end
      end
      LOAD_W: begin
        if (cnt == VW'(ROWS)) begin
          state_nxt = (nvec != '0) ? STREAM : DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + VW'(1);
        end
      end
      STREAM: begin
        if (cnt == nvec - VW'(1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + VW'(1);
        end
      end
      DRAIN: begin
        // Last vector's final column fires VLEN cycles after its read.
        if (cnt == VW'(VLEN - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + VW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Outputs are decoded from the next state so they appear as flops aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      wght_rd_en    <= 1'b0;
      wght_rd_addr  <= '0;
      load_wght     <= 1'b0;
      ifmap_rd_en   <= 1'b0;
      ifmap_rd_addr <= '0;
    end else begin
      busy          <= (state_nxt != IDLE);
      done          <= (state_nxt == DONE);
      wght_rd_en    <= (state_nxt == LOAD_W) && (cnt_nxt < VW'(ROWS));
      wght_rd_addr  <= ((state_nxt == LOAD_W) && (cnt_nxt < VW'(ROWS)))
                       ? (RW'(ROWS - 1) - cnt_nxt[RW-1:0]) : '0;
      load_wght     <= (state_nxt == LOAD_W) && (cnt_nxt != '0);
      ifmap_rd_en   <= (state_nxt == STREAM);
      ifmap_rd_addr <= (state_nxt == STREAM) ? cnt_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= '0;
      for (int i = 0; i < ARR_LAT; i++) ipipe[i] <= '0;
    end else if (abort && state != IDLE) begin
      vpipe <= '0;
      for (int i = 0; i < ARR_LAT; i++) ipipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[VLEN-2:0], ifmap_rd_en};
      ipipe[0] <= ifmap_rd_addr;
      for (int i = 1; i < ARR_LAT; i++) ipipe[i] <= ipipe[i-1];
    end
  end

  assign psum_valid = vpipe[VLEN-1 -: COLS];
  assign psum_idx   = ipipe[ARR_LAT-1];

endmodule
